// File: rtl/snake_body_pkg.sv
// Shared types and helpers for the snake body block: headings, FSM states,
// playfield bounds and per-tile coordinate stepping.
package snake_body_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_e;

    typedef enum logic [0:0] {
        StWalk   = 1'b0,
        StUpdate = 1'b1
    } state_e;

    // Playfield spans 1..GameWidth by 1..GameHeight; row/column 0 is wall.
    localparam logic [4:0] GameWidth  = 5'd18;
    localparam logic [3:0] GameHeight = 4'd13;

    // Opposite heading: flip bit 0.
    function automatic dir_e dir_opposite(dir_e d);
        return dir_e'({d[1], ~d[0]});
    endfunction

    function automatic logic [4:0] step_x(logic [4:0] x, dir_e d);
        logic [4:0] r;
        case (d)
            DirLeft:  r = x - 5'd1;
            DirRight: r = x + 5'd1;
            default:  r = x;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] step_y(logic [3:0] y, dir_e d);
        logic [3:0] r;
        case (d)
            DirUp:   r = y - 4'd1;
            DirDown: r = y + 4'd1;
            default: r = y;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_body_dir_ring.sv
// Ring buffer of per-segment directions. Entry hidx+i holds the direction from
// segment i toward segment i+1. Reset lays the body out to the left of the head.
module snake_body_dir_ring
    import snake_body_pkg::*;
#(
    parameter int unsigned MaxLen = 64,
    parameter int unsigned AddrW  = $clog2(MaxLen)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  dir_e             wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output dir_e             rdata_o
);

    dir_e mem_q [MaxLen];

    // Storage: synchronous fill with LEFT on reset, single write port otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MaxLen); i++) begin
                mem_q[i] <= DirLeft;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/snake_body.sv
// Snake state owner: head, direction ring and length. Continuously walks the
// body head-to-tail emitting one segment per clock, applies pending steps
// between passes, and flags wall and self collisions.
module snake_body
    import snake_body_pkg::*;
#(
    parameter int unsigned MaxLen   = 64,
    parameter int unsigned StartLen = 3,
    parameter int unsigned StartX   = 4,
    parameter int unsigned StartY   = 7
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       game_rst_ni,
    input  logic       step_i,
    input  logic [1:0] move_dir_i,
    input  logic       grow_i,
    output logic       step_done_o,
    output logic [4:0] snake_head_x_o,
    output logic [3:0] snake_head_y_o,
    output logic [4:0] snake_x_o,
    output logic [3:0] snake_y_o,
    output logic [1:0] snake_dir_o,
    output logic       snake_first_o,
    output logic       snake_last_o,
    output logic       snake_valid_o,
    output logic [6:0] length_o,
    output logic       wall_hit_o,
    output logic       self_hit_o,
    output logic       full_o
);

    localparam int unsigned AddrW = $clog2(MaxLen);

    logic             rst_all_n;
    state_e           state_q, state_d;
    logic [AddrW-1:0] idx_q, idx_d;
    logic [AddrW-1:0] hidx_q, hidx_d;
    logic [4:0]       cur_x_q, cur_x_d, head_x_q, head_x_d;
    logic [3:0]       cur_y_q, cur_y_d, head_y_q, head_y_d;
    dir_e             heading_q, heading_d;
    logic [6:0]       len_q, len_d;
    logic             pend_q, pend_d, pend_grow_q, pend_grow_d;
    dir_e             pend_dir_q, pend_dir_d;
    logic             check_q, check_d;
    logic             wall_q, wall_d, self_q, self_d, done_q, done_d;
    logic [4:0]       sx_q, sx_d;
    logic [3:0]       sy_q, sy_d;
    dir_e             sdir_q, sdir_d;
    logic             sfirst_q, sfirst_d, slast_q, slast_d, svalid_q, svalid_d;

    logic             ring_we;
    logic [AddrW-1:0] ring_waddr, ring_raddr;
    dir_e             ring_wdata, seg_dir, app_dir;
    logic [4:0]       nx;
    logic [3:0]       ny;
    logic             is_last, is_full, off_field;

    assign rst_all_n  = rst_ni & game_rst_ni;
    assign ring_raddr = hidx_q + idx_q;
    assign is_last    = 7'(idx_q) == (len_q - 7'd1);
    assign is_full    = len_q == 7'(MaxLen);
    // A reversal request would fold the head into the neck; keep going straight.
    assign app_dir    = (pend_dir_q == dir_opposite(heading_q)) ? heading_q : pend_dir_q;
    assign nx         = step_x(head_x_q, app_dir);
    assign ny         = step_y(head_y_q, app_dir);
    assign off_field  = (nx == 5'd0) || (nx > GameWidth) || (ny == 4'd0) || (ny > GameHeight);

    snake_body_dir_ring #(
        .MaxLen (MaxLen),
        .AddrW  (AddrW)
    ) u_dir_ring (
        .clk_i   (clk_i),
        .rst_ni  (rst_all_n),
        .we_i    (ring_we),
        .waddr_i (ring_waddr),
        .wdata_i (ring_wdata),
        .raddr_i (ring_raddr),
        .rdata_o (seg_dir)
    );

    // Next state: walk the body, or apply the latched step between passes.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hidx_d      = hidx_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        heading_d   = heading_q;
        len_d       = len_q;
        pend_d      = pend_q;
        pend_dir_d  = pend_dir_q;
        pend_grow_d = pend_grow_q;
        check_d     = check_q;
        wall_d      = wall_q;
        self_d      = self_q;
        done_d      = 1'b0;
        sx_d        = sx_q;
        sy_d        = sy_q;
        sdir_d      = sdir_q;
        sfirst_d    = sfirst_q;
        slast_d     = slast_q;
        svalid_d    = 1'b0;
        ring_we     = 1'b0;
        ring_waddr  = hidx_q - AddrW'(1);
        ring_wdata  = dir_opposite(app_dir);

        unique case (state_q)
            StWalk: begin
                svalid_d = 1'b1;
                sx_d     = cur_x_q;
                sy_d     = cur_y_q;
                sdir_d   = seg_dir;
                sfirst_d = (idx_q == '0);
                slast_d  = is_last;
                if (check_q && (idx_q != '0) && (cur_x_q == head_x_q) && (cur_y_q == head_y_q)) begin
                    self_d = 1'b1;
                end
                cur_x_d = step_x(cur_x_q, seg_dir);
                cur_y_d = step_y(cur_y_q, seg_dir);
                idx_d   = idx_q + AddrW'(1);
                if (is_last) begin
                    check_d = 1'b0;
                    idx_d   = '0;
                    cur_x_d = head_x_q;
                    cur_y_d = head_y_q;
                    if (pend_q) begin
                        state_d = StUpdate;
                    end
                end
            end
            StUpdate: begin
                done_d  = 1'b1;
                pend_d  = 1'b0;
                state_d = StWalk;
                idx_d   = '0;
                cur_x_d = head_x_q;
                cur_y_d = head_y_q;
                if (off_field) begin
                    wall_d = 1'b1;
                end else begin
                    ring_we   = 1'b1;
                    hidx_d    = hidx_q - AddrW'(1);
                    heading_d = app_dir;
                    head_x_d  = nx;
                    head_y_d  = ny;
                    cur_x_d   = nx;
                    cur_y_d   = ny;
                    check_d   = 1'b1;
                    // Without growth the fixed length implicitly drops the old tail.
                    if (pend_grow_q && !is_full) begin
                        len_d = len_q + 7'd1;
                    end
                end
            end
            default: state_d = StWalk;
        endcase

        // A new step overrides the latch, including one arriving during update.
        if (step_i) begin
            pend_d      = 1'b1;
            pend_dir_d  = dir_e'(move_dir_i);
            pend_grow_d = grow_i;
        end
    end

    // State and output registers with synchronous game/system reset.
    always_ff @(posedge clk_i) begin
        if (!rst_all_n) begin
            state_q     <= StWalk;
            idx_q       <= '0;
            hidx_q      <= '0;
            cur_x_q     <= 5'(StartX);
            cur_y_q     <= 4'(StartY);
            head_x_q    <= 5'(StartX);
            head_y_q    <= 4'(StartY);
            heading_q   <= DirRight;
            len_q       <= 7'(StartLen);
            pend_q      <= 1'b0;
            pend_dir_q  <= DirRight;
            pend_grow_q <= 1'b0;
            check_q     <= 1'b0;
            wall_q      <= 1'b0;
            self_q      <= 1'b0;
            done_q      <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            sdir_q      <= DirUp;
            sfirst_q    <= 1'b0;
            slast_q     <= 1'b0;
            svalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hidx_q      <= hidx_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            heading_q   <= heading_d;
            len_q       <= len_d;
            pend_q      <= pend_d;
            pend_dir_q  <= pend_dir_d;
            pend_grow_q <= pend_grow_d;
            check_q     <= check_d;
            wall_q      <= wall_d;
            self_q      <= self_d;
            done_q      <= done_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            sdir_q      <= sdir_d;
            sfirst_q    <= sfirst_d;
            slast_q     <= slast_d;
            svalid_q    <= svalid_d;
        end
    end

    assign step_done_o    = done_q;
    assign snake_head_x_o = head_x_q;
    assign snake_head_y_o = head_y_q;
    assign snake_x_o      = sx_q;
    assign snake_y_o      = sy_q;
    assign snake_dir_o    = sdir_q;
    assign snake_first_o  = sfirst_q;
    assign snake_last_o   = slast_q;
    assign snake_valid_o  = svalid_q;
    assign length_o       = len_q;
    assign wall_hit_o     = wall_q;
    assign self_hit_o     = self_q;
    assign full_o         = is_full;

endmodule
